// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared types and constants for the CRC test stage and its compare monitor
package crc_pkg;

   localparam int CRC_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } cmon_state_t;

   typedef struct packed {
      logic [CRC_WIDTH_DEF-1:0] checksum;
      logic                     match;
      logic [7:0]               seq;
   } cmon_result_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear (clear wins over increment)
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/crc_compare_monitor.sv
// rtl/crc_compare_monitor.sv - captures two CRC engine results after a settle delay,
// compares them and presents a valid/ready record plus debug counters
module crc_compare_monitor
   import crc_pkg::*;
#(
   parameter int CRC_WIDTH     = CRC_WIDTH_DEF,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 crc_en,
   input  logic [CRC_WIDTH-1:0] checksum1,
   input  logic [CRC_WIDTH-1:0] checksum2,
   input  logic                 clear,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [CRC_WIDTH-1:0] m_checksum,
   output logic                 m_match,
   output logic [7:0]           m_seq,
   output logic [CNT_WIDTH-1:0] pass_cnt,
   output logic [CNT_WIDTH-1:0] fail_cnt,
   output logic [CNT_WIDTH-1:0] overrun_cnt,
   output logic                 busy
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);

   cmon_state_t   state_q, state_d;
   logic [SW-1:0] settle_cnt;
   logic          sums_equal;
   logic          capture;

   assign sums_equal = (checksum1 == checksum2);
   assign capture    = (state_q == CAPTURE);
   assign busy       = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (crc_en) state_d = (SETTLE_CYCLES == 1) ? CAPTURE : SETTLE;
         SETTLE:  if (settle_cnt == '0) state_d = CAPTURE;
         CAPTURE: state_d = HOLD;
         HOLD:    if (m_valid && m_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         settle_cnt <= '0;
         m_valid    <= 1'b0;
         m_checksum <= '0;
         m_match    <= 1'b0;
         m_seq      <= 8'd0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            settle_cnt <= SETTLE_LOAD;
         end else if ((state_q == SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SW'(1);
         end
         if (capture) begin
            m_checksum <= checksum1;
            m_match    <= sums_equal;
            m_seq      <= m_seq + 8'd1;
         end
         // valid trails HOLD entry by one cycle; the record regs are already stable then
         if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end else if (state_q == HOLD) begin
            m_valid <= 1'b1;
         end
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_pass_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (capture && sums_equal),
      .clear (clear),
      .count (pass_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_fail_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (capture && !sums_equal),
      .clear (clear),
      .count (fail_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_overrun_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (crc_en && busy),
      .clear (clear),
      .count (overrun_cnt)
   );

endmodule

// File: tb/tb_crc_compare_monitor.sv
// tb/tb_crc_compare_monitor.sv - directed self-checking bench for crc_compare_monitor
module tb_crc_compare_monitor;

   logic        clk = 1'b0;
   logic        rstn;
   logic        crc_en;
   logic [15:0] checksum1;
   logic [15:0] checksum2;
   logic        clear;
   logic        m_ready;

   logic        m_valid0, m_match0, busy0;
   logic [15:0] m_checksum0;
   logic [7:0]  m_seq0;
   logic [3:0]  pass0, fail0, ovr0;

   logic        m_valid1, m_match1, busy1;
   logic [15:0] m_checksum1;
   logic [7:0]  m_seq1;
   logic [15:0] pass1, fail1, ovr1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   crc_compare_monitor #(.CRC_WIDTH(16), .SETTLE_CYCLES(2), .CNT_WIDTH(4)) u0 (
      .clk(clk), .rstn(rstn), .crc_en(crc_en), .checksum1(checksum1), .checksum2(checksum2),
      .clear(clear), .m_valid(m_valid0), .m_ready(m_ready), .m_checksum(m_checksum0),
      .m_match(m_match0), .m_seq(m_seq0), .pass_cnt(pass0), .fail_cnt(fail0),
      .overrun_cnt(ovr0), .busy(busy0)
   );

   crc_compare_monitor #(.CRC_WIDTH(16), .SETTLE_CYCLES(1), .CNT_WIDTH(16)) u1 (
      .clk(clk), .rstn(rstn), .crc_en(crc_en), .checksum1(checksum1), .checksum2(checksum2),
      .clear(clear), .m_valid(m_valid1), .m_ready(m_ready), .m_checksum(m_checksum1),
      .m_match(m_match1), .m_seq(m_seq1), .pass_cnt(pass1), .fail_cnt(fail1),
      .overrun_cnt(ovr1), .busy(busy1)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_run(input logic [15:0] c1, input logic [15:0] c2);
      int n;
      checksum1 = c1;
      checksum2 = c2;
      m_ready   = 1'b1;
      crc_en    = 1'b1;
      step();
      crc_en = 1'b0;
      n = 0;
      while (!m_valid0 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (m_valid0 !== 1'b1) begin
         failures++;
         $display("FAIL run_timeout m_valid=%b required=1", m_valid0);
      end
      step();
   endtask

   task automatic test_reset();
      rstn = 1'b0; crc_en = 1'b0; clear = 1'b0; m_ready = 1'b0;
      checksum1 = 16'h0; checksum2 = 16'h0;
      step(); step();
      checks++;
      if ({m_valid0, busy0, m_match0, m_checksum0, m_seq0, pass0, fail0, ovr0} !== '0) begin
         failures++;
         $display("FAIL reset_state u0 v=%b b=%b m=%b cs=%h seq=%0d p=%0d f=%0d o=%0d required all 0",
                  m_valid0, busy0, m_match0, m_checksum0, m_seq0, pass0, fail0, ovr0);
      end
      rstn = 1'b1;
      step();
   endtask

   task automatic test_match();
      checksum1 = 16'h1D0F; checksum2 = 16'h1D0F; m_ready = 1'b1;
      crc_en = 1'b1;
      step();                       // edge N
      crc_en = 1'b0;
      checks++;
      if (busy0 !== 1'b1 || m_valid0 !== 1'b0) begin
         failures++;
         $display("FAIL match_busy_rise busy=%b m_valid=%b required busy=1 m_valid=0", busy0, m_valid0);
      end
      step();                       // edge N+1
      checks++;
      if (m_valid0 !== 1'b0 || pass0 !== 4'd0) begin
         failures++;
         $display("FAIL match_early m_valid=%b pass=%0d required 0 0", m_valid0, pass0);
      end
      step();                       // edge N+2: capture
      checks++;
      if (m_checksum0 !== 16'h1D0F || pass0 !== 4'd1 || m_seq0 !== 8'd1 || m_valid0 !== 1'b0) begin
         failures++;
         $display("FAIL match_capture cs=%h pass=%0d seq=%0d v=%b required 1d0f 1 1 0",
                  m_checksum0, pass0, m_seq0, m_valid0);
      end
      checks++;
      if (m_valid1 !== 1'b1 || m_checksum1 !== 16'h1D0F || pass1 !== 16'd1) begin
         failures++;
         $display("FAIL settle1_valid v=%b cs=%h pass=%0d required 1 1d0f 1", m_valid1, m_checksum1, pass1);
      end
      step();                       // edge N+3
      checks++;
      if (m_valid0 !== 1'b1 || m_match0 !== 1'b1) begin
         failures++;
         $display("FAIL match_valid v=%b match=%b required 1 1", m_valid0, m_match0);
      end
      checks++;
      if (m_valid1 !== 1'b0 || busy1 !== 1'b0) begin
         failures++;
         $display("FAIL settle1_handshake v=%b busy=%b required 0 0", m_valid1, busy1);
      end
      step();                       // edge N+4: handshake
      checks++;
      if (m_valid0 !== 1'b0 || busy0 !== 1'b0) begin
         failures++;
         $display("FAIL match_handshake v=%b busy=%b required 0 0", m_valid0, busy0);
      end
   endtask

   task automatic test_mismatch();
      do_run(16'h1D0F, 16'h1D0E);
      checks++;
      if (m_match0 !== 1'b0 || fail0 !== 4'd1 || pass0 !== 4'd1 || m_seq0 !== 8'd2) begin
         failures++;
         $display("FAIL mismatch match=%b fail=%0d pass=%0d seq=%0d required 0 1 1 2",
                  m_match0, fail0, pass0, m_seq0);
      end
   endtask

   task automatic test_backpressure();
      int n;
      int bad;
      checksum1 = 16'hABCD; checksum2 = 16'hABCD; m_ready = 1'b0;
      crc_en = 1'b1;
      step();
      crc_en = 1'b0;
      n = 0;
      while (!m_valid0 && n < 20) begin
         step();
         n++;
      end
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         crc_en = (i == 1 || i == 3);
         step();
         if (m_valid0 !== 1'b1 || m_checksum0 !== 16'hABCD || m_match0 !== 1'b1 || m_seq0 !== 8'd3) bad++;
      end
      crc_en = 1'b0;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL hold_stable unstable_cycles=%0d required 0", bad);
      end
      m_ready = 1'b1;
      step();
      checks++;
      if (m_valid0 !== 1'b0 || busy0 !== 1'b0 || ovr0 !== 4'd2 || ovr1 !== 16'd2) begin
         failures++;
         $display("FAIL overrun v=%b busy=%b ovr0=%0d ovr1=%0d required 0 0 2 2", m_valid0, busy0, ovr0, ovr1);
      end
      step(); step(); step();
      checks++;
      if (m_valid0 !== 1'b0 || m_seq0 !== 8'd3 || pass0 !== 4'd2) begin
         failures++;
         $display("FAIL single_handshake v=%b seq=%0d pass=%0d required 0 3 2", m_valid0, m_seq0, pass0);
      end
   endtask

   task automatic test_saturation_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if (pass0 !== 4'd0 || fail0 !== 4'd0 || ovr0 !== 4'd0 || m_seq0 !== 8'd3) begin
         failures++;
         $display("FAIL clear p=%0d f=%0d o=%0d seq=%0d required 0 0 0 3", pass0, fail0, ovr0, m_seq0);
      end
      for (int i = 0; i < 17; i++) do_run(16'h5A5A, 16'h5A5A);
      checks++;
      if (pass0 !== 4'd15 || m_seq0 !== 8'd20) begin
         failures++;
         $display("FAIL saturate pass=%0d seq=%0d required 15 20", pass0, m_seq0);
      end
      checksum1 = 16'h0F0F; checksum2 = 16'h0F0F; m_ready = 1'b1;
      crc_en = 1'b1;
      step();                       // edge N
      crc_en = 1'b0;
      step();                       // edge N+1
      clear = 1'b1;
      step();                       // edge N+2: capture with clear
      clear = 1'b0;
      checks++;
      if (pass0 !== 4'd0 || m_seq0 !== 8'd21 || m_checksum0 !== 16'h0F0F) begin
         failures++;
         $display("FAIL clear_capture pass=%0d seq=%0d cs=%h required 0 21 0f0f", pass0, m_seq0, m_checksum0);
      end
      step();
      checks++;
      if (m_valid0 !== 1'b1) begin
         failures++;
         $display("FAIL clear_keeps_fsm m_valid=%b required 1", m_valid0);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int seen;
      checksum1 = 16'h1234; checksum2 = 16'h1234; m_ready = 1'b1;
      crc_en = 1'b1;
      step();
      crc_en = 1'b0;
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({m_valid0, busy0, m_match0, m_checksum0, m_seq0, pass0, fail0, ovr0} !== '0) begin
         failures++;
         $display("FAIL async_reset v=%b b=%b m=%b cs=%h seq=%0d p=%0d f=%0d o=%0d required all 0",
                  m_valid0, busy0, m_match0, m_checksum0, m_seq0, pass0, fail0, ovr0);
      end
      @(negedge clk);
      rstn = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (m_valid0 || busy0 || m_valid1 || busy1) seen++;
      end
      checks++;
      if (seen != 0 || pass0 !== 4'd0) begin
         failures++;
         $display("FAIL reset_no_record active_cycles=%0d pass=%0d required 0 0", seen, pass0);
      end
   endtask

   task automatic test_seq_wrap();
      logic [7:0] exp_seq;
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         do_run(16'(i), 16'(i ^ (i & 1)));
         exp_seq = 8'(i + 1);
         if (m_seq0 !== exp_seq) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL seq_progress wrong_records=%0d required 0", bad);
      end
      checks++;
      if (m_seq0 !== 8'd0 || m_checksum0 !== 16'h00FF || m_match0 !== 1'b0) begin
         failures++;
         $display("FAIL seq_wrap seq=%0d cs=%h match=%b required 0 00ff 0", m_seq0, m_checksum0, m_match0);
      end
      checks++;
      if (pass0 !== 4'd15 || fail0 !== 4'd15 || ovr0 !== 4'd0) begin
         failures++;
         $display("FAIL wrap_counters p=%0d f=%0d o=%0d required 15 15 0", pass0, fail0, ovr0);
      end
   endtask

   initial begin
      test_reset();
      test_match();
      test_mismatch();
      test_backpressure();
      test_saturation_clear();
      test_reset_mid();
      test_seq_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
